// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with ECALL/EBREAK/MRET and external interrupt trap sequencing.
// States: RUN executes and takes events, TRAP redirects to the handler, RET redirects to mepc.
module csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100,
  parameter int              SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               instr_valid_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               csr_en_i,
  input  logic [1:0]         csr_op_i,
  input  logic               csr_imm_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [4:0]         zimm_i,
  input  logic               ecall_i,
  input  logic               ebreak_i,
  input  logic               mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  output logic               csr_illegal_o,
  output logic               redirect_o,
  output logic [XLEN-1:0]    redirect_pc_o
);

  localparam int IRQ_LSB = 16;

  typedef enum logic [1:0] {RUN, TRAP, RET} state_t;

  state_t             state_q;
  logic               redirect_q;
  logic [XLEN-1:0]    redirect_pc_q;
  logic               mstatus_mie_q, mstatus_mpie_q;
  logic [NUM_IRQ-1:0] mie_q;
  logic [XLEN-1:0]    mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

  logic [NUM_IRQ-1:0] sync_irq, pend;
  logic [4:0]         irq_code;
  logic               implemented;
  logic [XLEN-1:0]    src, wdata, trap_base, irq_target;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_irq = sync_q[SYNC_STAGES-1];
  assign pend     = sync_irq & mie_q & {NUM_IRQ{mstatus_mie_q}};

  always_comb begin
    irq_code = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) irq_code = 5'(IRQ_LSB + i);
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    implemented = 1'b1;
    case (csr_addr_i)
      12'h300: begin
        csr_rdata_o[3] = mstatus_mie_q;
        csr_rdata_o[7] = mstatus_mpie_q;
      end
      12'h304: csr_rdata_o[IRQ_LSB +: NUM_IRQ] = mie_q;
      12'h305: csr_rdata_o = mtvec_q;
      12'h340: csr_rdata_o = mscratch_q;
      12'h341: csr_rdata_o = mepc_q;
      12'h342: csr_rdata_o = mcause_q;
      12'h344: csr_rdata_o[IRQ_LSB +: NUM_IRQ] = sync_irq;
      default: implemented = 1'b0;
    endcase
  end

  assign csr_illegal_o = csr_en_i & ~implemented;
  assign src           = csr_imm_i ? XLEN'(zimm_i) : rs1_data_i;

  always_comb begin
    case (csr_op_i)
      2'b01:   wdata = src;
      2'b10:   wdata = csr_rdata_o | src;
      2'b11:   wdata = csr_rdata_o & ~src;
      default: wdata = csr_rdata_o;
    endcase
  end

  assign trap_base  = mtvec_q & ~XLEN'(3);
  assign irq_target = trap_base + (mtvec_q[0] ? XLEN'({irq_code, 2'b00}) : '0);

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC & ~XLEN'(2);
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      case (state_q)
        RUN: begin
          redirect_q <= 1'b0;
          if (instr_valid_i) begin
            if (ecall_i || ebreak_i) begin
              mepc_q         <= pc_i & ~XLEN'(1);
              mcause_q       <= ecall_i ? XLEN'(11) : XLEN'(3);
              mstatus_mpie_q <= mstatus_mie_q;
              mstatus_mie_q  <= 1'b0;
              redirect_q     <= 1'b1;
              redirect_pc_q  <= trap_base;
              state_q        <= TRAP;
            end else if (|pend) begin
              // The interrupted instruction does not retire, so its CSR write is dropped.
              mepc_q         <= pc_i & ~XLEN'(1);
              mcause_q       <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
              mstatus_mpie_q <= mstatus_mie_q;
              mstatus_mie_q  <= 1'b0;
              redirect_q     <= 1'b1;
              redirect_pc_q  <= irq_target;
              state_q        <= TRAP;
            end else begin
              if (csr_en_i && csr_op_i != 2'b00) begin
                case (csr_addr_i)
                  12'h300: begin
                    mstatus_mie_q  <= wdata[3];
                    mstatus_mpie_q <= wdata[7];
                  end
                  12'h304: mie_q      <= wdata[IRQ_LSB +: NUM_IRQ];
                  12'h305: mtvec_q    <= wdata & ~XLEN'(2);
                  12'h340: mscratch_q <= wdata;
                  12'h341: mepc_q     <= wdata & ~XLEN'(1);
                  12'h342: mcause_q   <= wdata;
                  default: ;
                endcase
              end
              if (mret_i) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
                redirect_q     <= 1'b1;
                redirect_pc_q  <= mepc_q;
                state_q        <= RET;
              end
            end
          end
        end
        default: begin
          redirect_q <= 1'b0;
          state_q    <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed scenarios plus randomized traffic against a word-level reference model.
module tb_csr_trap_unit;
  localparam int SYNC = 2;
  localparam bit [31:0] MIE_MASK = 32'h000F_0000;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        instr_valid_i = 0, csr_en_i = 0, csr_imm_i = 0;
  logic        ecall_i = 0, ebreak_i = 0, mret_i = 0;
  logic [31:0] pc_i = 0, rs1_data_i = 0;
  logic [1:0]  csr_op_i = 0;
  logic [11:0] csr_addr_i = 0;
  logic [4:0]  zimm_i = 0;
  logic [3:0]  irq_i = 0;
  logic [31:0] csr_rdata_o, redirect_pc_o;
  logic        csr_illegal_o, redirect_o;

  int n_tests = 0, n_fail = 0;

  csr_trap_unit #(.XLEN(32), .NUM_IRQ(4), .RESET_MTVEC(32'h100), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid_i), .pc_i(pc_i),
    .csr_en_i(csr_en_i), .csr_op_i(csr_op_i), .csr_imm_i(csr_imm_i), .csr_addr_i(csr_addr_i),
    .rs1_data_i(rs1_data_i), .zimm_i(zimm_i), .ecall_i(ecall_i), .ebreak_i(ebreak_i),
    .mret_i(mret_i), .irq_i(irq_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o));

  always #5 clk_i = ~clk_i;

  // Reference model: whole CSR words, masked on access; irq delay as a FIFO of samples.
  bit [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_rpc;
  bit        m_redirect;
  bit [3:0]  m_irqq[$];

  function automatic bit m_legal(bit [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344};
  endfunction

  function automatic bit [31:0] m_rd(bit [11:0] a);
    case (a)
      12'h300: return m_mstatus & 32'h88;
      12'h304: return m_mie & MIE_MASK;
      12'h305: return m_mtvec & ~32'h2;
      12'h340: return m_mscratch;
      12'h341: return m_mepc & ~32'h1;
      12'h342: return m_mcause;
      12'h344: return {12'b0, m_irqq[0], 16'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_wr(bit [11:0] a, bit [31:0] v);
    case (a)
      12'h300: m_mstatus  = v & 32'h88;
      12'h304: m_mie      = v & MIE_MASK;
      12'h305: m_mtvec    = v;
      12'h340: m_mscratch = v;
      12'h341: m_mepc     = v;
      12'h342: m_mcause   = v;
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_redirect = 0; m_rpc = 0;
    m_irqq.delete();
    for (int i = 0; i < SYNC; i++) m_irqq.push_back(4'b0);
  endtask

  task automatic take_trap(bit [31:0] cause, bit [31:0] target);
    m_mepc = pc_i; m_mcause = cause;
    m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    m_rpc = target;
  endtask

  // Advance one clock edge, updating the model from the inputs currently driven.
  task automatic tick();
    bit nr = 0;
    bit [31:0] npc = m_rpc, pend, src, old, old_mepc;
    int win;
    if (!m_redirect && instr_valid_i) begin
      pend = m_mstatus[3] ? ({28'b0, m_irqq[0]} << 16) & m_mie : 32'h0;
      if (ecall_i || ebreak_i) begin
        take_trap(ecall_i ? 32'd11 : 32'd3, m_mtvec & ~32'h3);
        nr = 1; npc = m_rpc;
      end else if (pend != 0) begin
        win = 0;
        for (int b = 31; b >= 0; b--) if (pend[b]) win = b;
        take_trap(32'h8000_0000 | win, (m_mtvec & ~32'h3) + (m_mtvec[0] ? 4 * win : 0));
        nr = 1; npc = m_rpc;
      end else begin
        old_mepc = m_rd(12'h341);
        if (csr_en_i && csr_op_i != 0 && m_legal(csr_addr_i)) begin
          old = m_rd(csr_addr_i);
          src = csr_imm_i ? {27'b0, zimm_i} : rs1_data_i;
          m_wr(csr_addr_i, csr_op_i == 1 ? src : csr_op_i == 2 ? (old | src) : (old & ~src));
        end
        if (mret_i) begin
          m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
          nr = 1; npc = old_mepc;
        end
      end
    end
    m_irqq.push_back(irq_i);
    m_irqq.delete(0);
    @(posedge clk_i); #1;
    m_redirect = nr; m_rpc = npc;
  endtask

  task automatic drive(bit v, bit [31:0] p, bit ce, bit [1:0] op, bit im, bit [11:0] a,
                       bit [31:0] r, bit [4:0] z, bit ec, bit eb, bit mr);
    instr_valid_i = v; pc_i = p; csr_en_i = ce; csr_op_i = op; csr_imm_i = im; csr_addr_i = a;
    rs1_data_i = r; zimm_i = z; ecall_i = ec; ebreak_i = eb; mret_i = mr;
  endtask

  task automatic peek(bit [11:0] a, output bit [31:0] v);
    drive(0, 0, 0, 0, 0, a, 0, 0, 0, 0, 0);
    #1 v = csr_rdata_o;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    bit [31:0] v;
    rst_i = 1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); irq_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 0; m_reset();
    n_tests++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b expected 0", redirect_o); end
    peek(12'h305, v);
    n_tests++; if (v !== 32'h100) begin n_fail++; $display("FAIL reset_mtvec: got %h expected 00000100", v); end
    peek(12'h300, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mstatus: got %h expected 0", v); end
    drive(1, 32'h10, 1, 2'b01, 0, 12'h340, 32'hDEADBEEF, 0, 0, 0, 0);
    #1 n_tests++; if (csr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL csrrw_old: got %h expected 0", csr_rdata_o); end
    tick();
    peek(12'h340, v);
    n_tests++; if (v !== 32'hDEADBEEF) begin n_fail++; $display("FAIL csrrw_new: got %h expected deadbeef", v); end
  endtask

  task automatic test_set_clear();
    bit [31:0] v;
    drive(1, 32'h14, 1, 2'b10, 1, 12'h304, 0, 5'd0, 0, 0, 0); tick();
    peek(12'h304, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL csrrsi_zero: got %h expected 0", v); end
    drive(1, 32'h18, 1, 2'b10, 0, 12'h304, 32'h0001_0000, 0, 0, 0, 0); tick();
    peek(12'h304, v);
    n_tests++; if (v !== 32'h0001_0000) begin n_fail++; $display("FAIL csrrs_mie: got %h expected 00010000", v); end
    drive(1, 32'h1C, 1, 2'b11, 0, 12'h304, 32'h0001_0000, 0, 0, 0, 0); tick();
    peek(12'h304, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL csrrc_mie: got %h expected 0", v); end
  endtask

  task automatic test_ecall_mret();
    bit [31:0] v;
    drive(1, 32'h20, 1, 2'b10, 1, 12'h300, 0, 5'd8, 0, 0, 0); tick();
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    n_tests++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h100) begin
      n_fail++; $display("FAIL ecall_redirect: got %b/%h expected 1/00000100", redirect_o, redirect_pc_o); end
    peek(12'h341, v);
    n_tests++; if (v !== 32'h40) begin n_fail++; $display("FAIL ecall_mepc: got %h expected 00000040", v); end
    peek(12'h342, v);
    n_tests++; if (v !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause: got %h expected 0000000b", v); end
    peek(12'h300, v);
    n_tests++; if (v !== 32'h80) begin n_fail++; $display("FAIL ecall_mstatus: got %h expected 00000080", v); end
    idle();
    n_tests++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL trap_one_cycle: got %b expected 0", redirect_o); end
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    n_tests++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h40) begin
      n_fail++; $display("FAIL mret_redirect: got %b/%h expected 1/00000040", redirect_o, redirect_pc_o); end
    peek(12'h300, v);
    n_tests++; if (v[3] !== 1'b1) begin n_fail++; $display("FAIL mret_mie: got %b expected 1", v[3]); end
    idle();
  endtask

  task automatic test_vectored_irq();
    bit [31:0] v;
    drive(1, 32'h44, 1, 2'b01, 0, 12'h305, 32'h201, 0, 0, 0, 0); tick();
    drive(1, 32'h48, 1, 2'b01, 0, 12'h304, 32'h000C_0000, 0, 0, 0, 0); tick();
    irq_i = 4'b1100;
    for (int k = 0; k < SYNC; k++) begin
      drive(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      n_tests++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL irq_sync_early: got %b expected 0 at cycle %0d", redirect_o, k); end
    end
    tick();
    n_tests++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h248) begin
      n_fail++; $display("FAIL irq_vector: got %b/%h expected 1/00000248", redirect_o, redirect_pc_o); end
    peek(12'h342, v);
    n_tests++; if (v !== 32'h8000_0012) begin n_fail++; $display("FAIL irq_mcause: got %h expected 80000012", v); end
    idle();
  endtask

  task automatic test_priority();
    bit [31:0] v;
    drive(1, 32'h5C, 1, 2'b10, 1, 12'h300, 0, 5'd8, 0, 0, 0); tick();
    n_tests++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL mie_write_same_edge: got %b expected 0", redirect_o); end
    drive(1, 32'h60, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    n_tests++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h200) begin
      n_fail++; $display("FAIL prio_redirect: got %b/%h expected 1/00000200", redirect_o, redirect_pc_o); end
    peek(12'h342, v);
    n_tests++; if (v !== 32'd11) begin n_fail++; $display("FAIL prio_mcause: got %h expected 0000000b", v); end
    idle();
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    n_tests++; if (redirect_pc_o !== 32'h60) begin n_fail++; $display("FAIL prio_mret: got %h expected 00000060", redirect_pc_o); end
    idle();
    drive(1, 32'h70, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    peek(12'h342, v);
    n_tests++; if (redirect_pc_o !== 32'h248 || v !== 32'h8000_0012) begin
      n_fail++; $display("FAIL irq_after_mret: got %h/%h expected 00000248/80000012", redirect_pc_o, v); end
    irq_i = 0;
    idle();
  endtask

  task automatic test_reset_in_trap();
    bit [31:0] v;
    drive(1, 32'h90, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    n_tests++; if (redirect_o !== 1'b1) begin n_fail++; $display("FAIL trap_entry: got %b expected 1", redirect_o); end
    #1 rst_i = 1;
    #1 n_tests++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL rst_redirect: got %b expected 0", redirect_o); end
    peek(12'h341, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mepc: got %h expected 0", v); end
    drive(0, 0, 1, 0, 0, 12'h7C0, 0, 0, 0, 0, 0);
    #1 n_tests++; if (csr_rdata_o !== 32'h0 || csr_illegal_o !== 1'b1) begin
      n_fail++; $display("FAIL illegal_addr: got %h/%b expected 0/1", csr_rdata_o, csr_illegal_o); end
    @(negedge clk_i); rst_i = 0; m_reset();
  endtask

  task automatic test_random();
    bit [11:0] addrs[8] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h7C0};
    bit [11:0] a;
    for (int n = 0; n < 600; n++) begin
      a = ($urandom_range(0, 9) < 8) ? addrs[$urandom_range(0, 7)] : 12'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom & ~32'h1, $urandom_range(0, 1), 2'($urandom),
            $urandom_range(0, 1), a, $urandom, 5'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) irq_i = 4'($urandom);
      #1;
      n_tests++; if (csr_rdata_o !== m_rd(a)) begin n_fail++; $display("FAIL rnd_rdata[%0d] addr %h: got %h expected %h", n, a, csr_rdata_o, m_rd(a)); end
      n_tests++; if (csr_illegal_o !== (csr_en_i && !m_legal(a))) begin
        n_fail++; $display("FAIL rnd_illegal[%0d]: got %b expected %b", n, csr_illegal_o, csr_en_i && !m_legal(a)); end
      tick();
      n_tests++; if (redirect_o !== m_redirect || (m_redirect && redirect_pc_o !== m_rpc)) begin
        n_fail++; $display("FAIL rnd_redirect[%0d]: got %b/%h expected %b/%h", n, redirect_o, redirect_pc_o, m_redirect, m_rpc); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_set_clear();
    test_ecall_mret();
    test_vectored_irq();
    test_priority();
    test_reset_in_trap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
